cpu_mult_iter: RTL and testbench

CPU_MULT_ITER -- requirements
Module: cpu_mult_iter

---
 rtl/cpu_mult_iter.sv | 174 +++++++++++++++++
 tb/tb_cpu_mult_iter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mult_iter.sv
// cpu_mult_iter: iterative multiplier built from a single LANE_W x LANE_W lane.
// The operands are split into LANES lanes and accumulated one partial product
// per cycle into a 2*DATA_W accumulator. A single fix-up cycle then converts
// the unsigned product into the signed one, and the selected half is presented
// with a valid/ready handshake.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - request valid          in_ready  - block idle, can accept
//   E_src1     - operand A              E_src2    - operand B
//   E_mode     - 00 low half; 01 high uu; 10 high su; 11 high ss
//   flush      - synchronous abort of the operation in flight
//   out_valid  - result available       out_ready - consumer accepts result
//   M_result   - selected half of the product, 0 outside DONE
module cpu_mult_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] M_result
);

    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned NPP   = LANES * LANES;
    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StFix,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [1:0]         mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    // The pp counter k is kept as its two digits (i = k mod LANES,
    // j = k / LANES), which avoids a divider for non power-of-two LANES.
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;

    logic [LANE_W-1:0]   a_lane;
    logic [LANE_W-1:0]   b_lane;
    logic [2*LANE_W-1:0] pp;
    logic [31:0]         shift_amt;
    logic [ACC_W-1:0]    pp_shifted;
    logic                i_last;
    logic                j_last;
    logic                a_neg;
    logic                b_neg;
    logic [ACC_W-1:0]    corr_a;
    logic [ACC_W-1:0]    corr_b;

    // Partial product datapath
    always_comb begin
        a_lane     = LANE_W'(a_q >> (LANE_W * 32'(i_q)));
        b_lane     = LANE_W'(b_q >> (LANE_W * 32'(j_q)));
        pp         = {{LANE_W{1'b0}}, a_lane} * {{LANE_W{1'b0}}, b_lane};
        shift_amt  = LANE_W * (32'(i_q) + 32'(j_q));
        pp_shifted = ACC_W'(pp) << shift_amt;
        i_last     = (i_q == IDX_W'(LANES - 1));
        j_last     = (j_q == IDX_W'(LANES - 1));
    end

    // Sign correction: the unsigned product of a negative two's-complement
    // operand overshoots by the other operand shifted up by DATA_W.
    always_comb begin
        a_neg  = mode_q[1] & a_q[DATA_W-1];
        b_neg  = (mode_q == 2'b11) & b_q[DATA_W-1];
        corr_a = a_neg ? {b_q, {DATA_W{1'b0}}} : '0;
        corr_b = b_neg ? {a_q, {DATA_W{1'b0}}} : '0;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;

        if (flush) begin
            // Flush wins over accept and completion alike.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_d     = E_src1;
                        b_d     = E_src2;
                        mode_d  = E_mode;
                        acc_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = StMul;
                    end
                end
                StMul: begin
                    acc_d = acc_q + pp_shifted;
                    if (i_last) begin
                        i_d = '0;
                        if (j_last) begin
                            j_d     = '0;
                            state_d = StFix;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                StFix: begin
                    // Low half is sign-independent, so mode 00 skips the fix-up.
                    if (mode_q != 2'b00) begin
                        acc_d = acc_q - corr_a - corr_b;
                    end
                    state_d = StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Outputs; in_ready is gated by reset_n so it stays low while reset is held.
    always_comb begin
        in_ready  = reset_n && (state_q == StIdle);
        out_valid = (state_q == StDone);
        M_result  = '0;
        if (state_q == StDone) begin
            M_result = (mode_q == 2'b00) ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:DATA_W];
        end
    end

endmodule

// File: tb/tb_cpu_mult_iter.sv
// Self-checking bench for cpu_mult_iter. A cycle-level reference model (golden
// product arithmetic plus latency/handshake rules) is compared against the
// 32/16 instance on every falling edge; directed vectors pin literal results.
// A second 24/8 instance gets a mixed-mode sweep against the golden product.
module tb_cpu_mult_iter;

    localparam int NPP1 = 4;   // (32/16)^2
    localparam int NPP2 = 9;   // (24/8)^2

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] src1, src2, m_result;
    logic [1:0]  mode;

    logic        in_valid2, in_ready2, out_valid2;
    logic [23:0] src1b, src2b, m_result2;
    logic [1:0]  mode2;
    logic        flush2 = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_mult_iter #(.DATA_W(32), .LANE_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E_src1    (src1),
        .E_src2    (src2),
        .E_mode    (mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .M_result  (m_result)
    );

    cpu_mult_iter #(.DATA_W(24), .LANE_W(8)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .E_src1    (src1b),
        .E_src2    (src2b),
        .E_mode    (mode2),
        .flush     (flush2),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .M_result  (m_result2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden product: extend each operand per mode, multiply, pick the half.
    function automatic logic [63:0] golden(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] m, input int dw);
        logic [127:0] mask, ae, be, p;
        mask = (128'(1) << dw) - 128'(1);
        ae   = 128'(a) & mask;
        be   = 128'(b) & mask;
        if (m[1] && a[dw-1]) ae = ae | ~mask;
        if (m == 2'b11 && b[dw-1]) be = be | ~mask;
        p = ae * be;
        if (m == 2'b00) return 64'(p & mask);
        return 64'((p >> dw) & mask);
    endfunction

    // Reference model for the 32/16 instance
    logic        idle_m = 1'b1;
    int          age = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ov;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_m = 1'b1;
            age    = 0;
        end else if (flush) begin
            idle_m = 1'b1;
        end else if (idle_m) begin
            if (in_valid) begin
                idle_m  = 1'b0;
                age     = 0;
                exp_res = 32'(golden(64'(src1), 64'(src2), mode, 32));
            end
        end else if (age >= NPP1 + 1) begin
            if (out_ready) idle_m = 1'b1;
        end else begin
            age++;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_m_result", 64'(m_result), 64'(0));
        end else begin
            exp_ov = !idle_m && (age >= NPP1 + 1);
            chk("in_ready", 64'(in_ready), 64'(idle_m));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("m_result", 64'(m_result), exp_ov ? 64'(exp_res) : 64'(0));
        end
    end

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got no out_valid, expected out_valid within budget", name);
    endtask

    // Issue one request; returns at the falling edge where out_valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        src1 = a; src2 = b; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        res = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) timeout_fail("op_timeout");
        res = m_result;
    endtask

    task automatic run_op2(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m);
        int lat;
        @(posedge clk); #1;
        src1b = a; src2b = b; mode2 = m; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid2) break;
        end
        if (!out_valid2) timeout_fail("op2_timeout");
        chk("w24_latency", 64'(lat), 64'(NPP2 + 2));
        chk("w24_result", 64'(m_result2), golden(64'(a), 64'(b), m, 24));
    endtask

    logic [31:0] res, rec;
    int          lat;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; mode = '0;
        in_valid2 = 1'b0; src1b = '0; src2b = '0; mode2 = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        // Directed vectors with literal expectations
        run_op(32'h0000FFFF, 32'h0000FFFF, 2'b00, res, lat);
        chk("ffff_sq_low", 64'(res), 64'hFFFE0001);
        chk("latency", 64'(lat), 64'(6));
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, res, lat);
        chk("m1_uu_high", 64'(res), 64'hFFFFFFFE);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, res, lat);
        chk("m1_ss_high", 64'(res), 64'h00000000);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, res, lat);
        chk("m1_low", 64'(res), 64'h00000001);
        run_op(32'hFFFFFFFF, 32'h00000002, 2'b10, res, lat);
        chk("m1x2_su_high", 64'(res), 64'hFFFFFFFF);
        run_op(32'hFFFFFFFF, 32'h00000002, 2'b01, res, lat);
        chk("m1x2_uu_high", 64'(res), 64'h00000001);
        run_op(32'h80000000, 32'h80000000, 2'b11, res, lat);
        chk("min_sq_ss_high", 64'(res), 64'h40000000);

        // Backpressure: hold DONE for 10 cycles, stray in_valid must be ignored
        @(posedge clk); #1 out_ready = 1'b0;
        run_op(32'h12345678, 32'h9ABCDEF0, 2'b11, rec, lat);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                src1 = 32'h1; src2 = 32'h1; mode = 2'b00; in_valid = 1'b1;
            end
            if (k == 5) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_hold", 64'(m_result), 64'(rec));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 64'(in_ready), 64'(1));

        // Flush on the third MUL cycle
        src1 = 32'hDEADBEEF; src2 = 32'h0BADF00D; mode = 2'b11; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_idle", 64'(in_ready), 64'(1));
        chk("flush_no_valid", 64'(out_valid), 64'(0));
        repeat (10) @(posedge clk);
        run_op(32'd7, 32'd9, 2'b00, res, lat);
        chk("after_flush_7x9", 64'(res), 64'h3F);

        // Flush with in_valid in IDLE accepts nothing
        @(posedge clk); #1;
        src1 = 32'd3; src2 = 32'd3; mode = 2'b00; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_idle", 64'(in_ready), 64'(1));
        repeat (8) @(posedge clk);

        // Flush together with out_ready in DONE
        run_op(32'd5, 32'd6, 2'b00, res, lat);
        chk("flush_done_result", 64'(res), 64'd30);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_done_idle", 64'(in_ready), 64'(1));
        chk("flush_done_no_valid", 64'(out_valid), 64'(0));
        repeat (3) @(posedge clk);

        // Reset during FIX
        #1 src1 = 32'hCAFEF00D; src2 = 32'h76543210; mode = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_fix_in_ready", 64'(in_ready), 64'(0));
        chk("rst_fix_out_valid", 64'(out_valid), 64'(0));
        chk("rst_fix_m_result", 64'(m_result), 64'(0));
        @(posedge clk); #1 reset_n = 1'b1;
        #1 chk("rst_release_in_ready", 64'(in_ready), 64'(1));
        repeat (12) @(posedge clk);

        // Mixed-mode sweep, 32/16: result checked here and by the compare process
        for (int n = 0; n < 12; n++) begin
            logic [31:0] a, b;
            logic [1:0]  m;
            a = $urandom();
            b = $urandom();
            m = 2'($urandom_range(0, 3));
            if (n == 0) a = 32'h80000000;
            if (n == 1) b = 32'h7FFFFFFF;
            run_op(a, b, m, res, lat);
            chk("sweep32", 64'(res), golden(64'(a), 64'(b), m, 32));
        end

        // Mixed-mode sweep, 24/8
        run_op2(24'hFFFFFF, 24'hFFFFFF, 2'b01);
        run_op2(24'hFFFFFF, 24'h000002, 2'b10);
        run_op2(24'h800000, 24'h800000, 2'b11);
        for (int n = 0; n < 12; n++) begin
            run_op2(24'($urandom()), 24'($urandom()), 2'($urandom_range(0, 3)));
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
